// File: rtl/id_ex_pipe_reg_if.sv
// ID->EX pipeline register bundle: decoded D-stage fields in, registered E-stage fields out.
// The master drives the D side and hazard controls; the slave (the register) drives E.
interface id_ex_pipe_reg_if #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 16
);
  logic               StallE;
  logic               FlushE;

  logic [XLEN-1:0]    RD1D, RD2D, PCD, PCPlus4D, ImmExtD;
  logic [RADDR_W-1:0] Rs1D, Rs2D, RdD;
  logic               RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD;
  logic [1:0]         ResultSrcD;
  logic [2:0]         ALUControlD;

  logic [XLEN-1:0]    RD1E, RD2E, PCE, PCPlus4E, ImmExtE;
  logic [RADDR_W-1:0] Rs1E, Rs2E, RdE;
  logic               RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0]         ResultSrcE;
  logic [2:0]         ALUControlE;
  logic               ValidE;
  logic [CNT_W-1:0]   BubbleCnt;

  modport master (
    output StallE, FlushE,
    output RD1D, RD2D, PCD, PCPlus4D, ImmExtD, Rs1D, Rs2D, RdD,
    output RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, ResultSrcD, ALUControlD,
    input  RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE,
    input  RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE,
    input  ValidE, BubbleCnt
  );

  modport slave (
    input  StallE, FlushE,
    input  RD1D, RD2D, PCD, PCPlus4D, ImmExtD, Rs1D, Rs2D, RdD,
    input  RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, ResultSrcD, ALUControlD,
    output RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE,
    output RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE,
    output ValidE, BubbleCnt
  );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// Decode-to-execute pipeline register: 1-cycle latency, stall holds, flush inserts a zeroed bubble.
// Update priority rst > FlushE > StallE > load; BubbleCnt counts flushes and saturates.
module id_ex_pipe_reg #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 16
) (
  input logic          clk,
  input logic          rst,
  id_ex_pipe_reg_if.slave bus
);

  typedef struct packed {
    logic [XLEN-1:0]    rd1;
    logic [XLEN-1:0]    rd2;
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    pc_plus4;
    logic [XLEN-1:0]    imm_ext;
    logic [RADDR_W-1:0] rs1;
    logic [RADDR_W-1:0] rs2;
    logic [RADDR_W-1:0] rd;
    logic               reg_write;
    logic               mem_write;
    logic               jump;
    logic               branch;
    logic               alu_src;
    logic [1:0]         result_src;
    logic [2:0]         alu_control;
  } stage_t;

  stage_t           stage_in;
  stage_t           stage_d, stage_q;
  logic             valid_d, valid_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    stage_in.rd1         = bus.RD1D;
    stage_in.rd2         = bus.RD2D;
    stage_in.pc          = bus.PCD;
    stage_in.pc_plus4    = bus.PCPlus4D;
    stage_in.imm_ext     = bus.ImmExtD;
    stage_in.rs1         = bus.Rs1D;
    stage_in.rs2         = bus.Rs2D;
    stage_in.rd          = bus.RdD;
    stage_in.reg_write   = bus.RegWriteD;
    stage_in.mem_write   = bus.MemWriteD;
    stage_in.jump        = bus.JumpD;
    stage_in.branch      = bus.BranchD;
    stage_in.alu_src     = bus.ALUSrcD;
    stage_in.result_src  = bus.ResultSrcD;
    stage_in.alu_control = bus.ALUControlD;
  end

  // Flush beats stall; a bubble also zeroes register addresses so the hazard unit ignores it.
  always_comb begin
    stage_d = stage_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (bus.FlushE) begin
      stage_d = '0;
      valid_d = 1'b0;
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (!bus.StallE) begin
      stage_d = stage_in;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      stage_q <= stage_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.RD1E        = stage_q.rd1;
  assign bus.RD2E        = stage_q.rd2;
  assign bus.PCE         = stage_q.pc;
  assign bus.PCPlus4E    = stage_q.pc_plus4;
  assign bus.ImmExtE     = stage_q.imm_ext;
  assign bus.Rs1E        = stage_q.rs1;
  assign bus.Rs2E        = stage_q.rs2;
  assign bus.RdE         = stage_q.rd;
  assign bus.RegWriteE   = stage_q.reg_write;
  assign bus.MemWriteE   = stage_q.mem_write;
  assign bus.JumpE       = stage_q.jump;
  assign bus.BranchE     = stage_q.branch;
  assign bus.ALUSrcE     = stage_q.alu_src;
  assign bus.ResultSrcE  = stage_q.result_src;
  assign bus.ALUControlE = stage_q.alu_control;
  assign bus.ValidE      = valid_q;
  assign bus.BubbleCnt   = cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: vector table through a scoreboard queue on the default build,
// plus a hand-driven counter saturation sequence on a CNT_W=2 build.
module tb_id_ex_pipe_reg;

  logic clk = 1'b0;
  logic rst;
  logic rst_s;

  always #5 clk = ~clk;

  id_ex_pipe_reg_if #(.XLEN(32), .RADDR_W(5), .CNT_W(16)) bus ();
  id_ex_pipe_reg_if #(.XLEN(32), .RADDR_W(5), .CNT_W(2))  sbus ();

  id_ex_pipe_reg #(.XLEN(32), .RADDR_W(5), .CNT_W(16)) u_dut (.clk(clk), .rst(rst),   .bus(bus));
  id_ex_pipe_reg #(.XLEN(32), .RADDR_W(5), .CNT_W(2))  u_sat (.clk(clk), .rst(rst_s), .bus(sbus));

  // ctrl bits: [9] RegWrite [8] MemWrite [7] Jump [6] Branch [5] ALUSrc [4:3] ResultSrc [2:0] ALUControl
  typedef struct packed {
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [9:0]  ctrl;
    logic [31:0] data;
  } dfields_t;

  typedef struct packed {
    logic [31:0] rd1, rd2, pc, pcp4, imm;
    logic [4:0]  rs1, rs2, rd;
    logic        regwrite, memwrite, jump, branch, alusrc;
    logic [1:0]  resultsrc;
    logic [2:0]  aluctl;
  } e_rec_t;

  typedef struct {
    logic     rst, stall, flush;
    dfields_t din;
    logic     bubble;
    dfields_t dexp;
    logic [15:0] cnt;
  } vec_t;

  typedef struct {
    e_rec_t      rec;
    logic        valid;
    logic [15:0] cnt;
  } exp_t;

  vec_t vecs[$];
  exp_t sbq[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic dfields_t mk(logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                                  logic [9:0] ctrl, logic [31:0] data);
    dfields_t f;
    f.rd = rd; f.rs1 = rs1; f.rs2 = rs2; f.ctrl = ctrl; f.data = data;
    return f;
  endfunction

  // Spread one compact field set over every D input so each E output carries a distinct value.
  function automatic e_rec_t expand(dfields_t f);
    e_rec_t r;
    r.rd1       = f.data;
    r.rd2       = ~f.data;
    r.pc        = {f.data[15:0], f.data[31:16]};
    r.pcp4      = f.data ^ 32'h5A5A_0F0F;
    r.imm       = f.data + 32'h0000_1234;
    r.rs1       = f.rs1;
    r.rs2       = f.rs2;
    r.rd        = f.rd;
    r.regwrite  = f.ctrl[9];
    r.memwrite  = f.ctrl[8];
    r.jump      = f.ctrl[7];
    r.branch    = f.ctrl[6];
    r.alusrc    = f.ctrl[5];
    r.resultsrc = f.ctrl[4:3];
    r.aluctl    = f.ctrl[2:0];
    return r;
  endfunction

  task automatic drive_d(input dfields_t f);
    e_rec_t r;
    r = expand(f);
    bus.RD1D = r.rd1; bus.RD2D = r.rd2; bus.PCD = r.pc; bus.PCPlus4D = r.pcp4; bus.ImmExtD = r.imm;
    bus.Rs1D = r.rs1; bus.Rs2D = r.rs2; bus.RdD = r.rd;
    bus.RegWriteD = r.regwrite; bus.MemWriteD = r.memwrite; bus.JumpD = r.jump;
    bus.BranchD = r.branch; bus.ALUSrcD = r.alusrc;
    bus.ResultSrcD = r.resultsrc; bus.ALUControlD = r.aluctl;
  endtask

  function automatic e_rec_t read_e();
    e_rec_t r;
    r.rd1 = bus.RD1E; r.rd2 = bus.RD2E; r.pc = bus.PCE; r.pcp4 = bus.PCPlus4E; r.imm = bus.ImmExtE;
    r.rs1 = bus.Rs1E; r.rs2 = bus.Rs2E; r.rd = bus.RdE;
    r.regwrite = bus.RegWriteE; r.memwrite = bus.MemWriteE; r.jump = bus.JumpE;
    r.branch = bus.BranchE; r.alusrc = bus.ALUSrcE;
    r.resultsrc = bus.ResultSrcE; r.aluctl = bus.ALUControlE;
    return r;
  endfunction

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic s, input logic f, input dfields_t din,
                     input logic bub, input dfields_t dexp, input logic [15:0] cnt);
    vec_t v;
    v.rst = r; v.stall = s; v.flush = f; v.din = din;
    v.bubble = bub; v.dexp = dexp; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  initial begin
    dfields_t va, vp, vl, vs, vf, vx, vx2, vz;
    exp_t     e, got;
    string    tag;

    va  = mk(5'd31, 5'd17, 5'd9,  10'h3FF,        32'hA5C3_1E77);
    vp  = mk(5'd5,  5'd3,  5'd0,  10'b1010110101, 32'hDEAD_BEEF);
    vl  = mk(5'd7,  5'd1,  5'd2,  10'h0A3,        32'h0000_0007);
    vs  = mk(5'd9,  5'd4,  5'd6,  10'h2C1,        32'h1357_9BDF);
    vf  = mk(5'd4,  5'd8,  5'd12, 10'h200,        32'hCAFE_F00D);
    vx  = mk(5'd11, 5'd12, 5'd13, 10'h155,        32'h0F0F_F0F0);
    vx2 = mk(5'd14, 5'd15, 5'd16, 10'h2AA,        32'h7777_0001);
    vz  = '0;

    //   rst stall flush din  bubble expected cnt
    add(1, 0, 0, va,  1, vz,  16'd0);   // reset with live inputs, two edges
    add(1, 0, 0, va,  1, vz,  16'd0);
    add(0, 0, 0, vp,  0, vp,  16'd0);   // pass-through
    add(0, 0, 0, vl,  0, vl,  16'd0);   // load RdD=7
    add(0, 1, 0, vs,  0, vl,  16'd0);   // stall x3 with RdD=9
    add(0, 1, 0, vs,  0, vl,  16'd0);
    add(0, 1, 0, vs,  0, vl,  16'd0);
    add(0, 0, 0, vs,  0, vs,  16'd0);   // stall released
    add(0, 1, 1, vf,  1, vz,  16'd1);   // flush wins over stall
    add(0, 0, 0, vx,  0, vx,  16'd1);
    add(0, 1, 0, vx2, 0, vx,  16'd1);   // counter holds under stall
    add(0, 0, 1, vx2, 1, vz,  16'd2);
    add(0, 1, 0, vx,  1, vz,  16'd2);   // stalled bubble stays a bubble
    add(1, 0, 1, va,  1, vz,  16'd0);   // reset beats flush, counter was 2
    add(0, 0, 0, vp,  0, vp,  16'd0);
    add(1, 1, 0, va,  1, vz,  16'd0);   // reset beats stall
    add(0, 0, 0, vl,  0, vl,  16'd0);

    rst = 1'b1; bus.StallE = 1'b0; bus.FlushE = 1'b0;
    drive_d(vz);
    rst_s = 1'b1; sbus.StallE = 1'b0; sbus.FlushE = 1'b0;
    sbus.RD1D = '0; sbus.RD2D = '0; sbus.PCD = '0; sbus.PCPlus4D = '0; sbus.ImmExtD = '0;
    sbus.Rs1D = '0; sbus.Rs2D = '0; sbus.RdD = '0;
    sbus.RegWriteD = 1'b0; sbus.MemWriteD = 1'b0; sbus.JumpD = 1'b0; sbus.BranchD = 1'b0;
    sbus.ALUSrcD = 1'b0; sbus.ResultSrcD = '0; sbus.ALUControlD = '0;

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; bus.StallE = vecs[i].stall; bus.FlushE = vecs[i].flush;
      drive_d(vecs[i].din);
      e.rec   = vecs[i].bubble ? '0 : expand(vecs[i].dexp);
      e.valid = ~vecs[i].bubble;
      e.cnt   = vecs[i].cnt;
      sbq.push_back(e);
      @(posedge clk);
      #1;
      // Disturb the D side before sampling: E must depend only on the last edge.
      drive_d(~vecs[i].din);
      bus.StallE = ~vecs[i].stall; bus.FlushE = ~vecs[i].flush; rst = ~vecs[i].rst;
      #1;
      got = sbq.pop_front();
      tag = $sformatf("v%0d", i);
      chk({tag, "_erec"},  192'(read_e()),       192'(got.rec));
      chk({tag, "_valid"}, 192'(bus.ValidE),     192'(got.valid));
      chk({tag, "_bcnt"},  192'(bus.BubbleCnt),  192'(got.cnt));
    end
    rst = 1'b0; bus.StallE = 1'b0; bus.FlushE = 1'b0;

    // Saturating counter on the 2-bit build
    rst_s = 1'b1; sbus.FlushE = 1'b0;
    @(posedge clk); #1;
    chk("sat_reset", 192'(sbus.BubbleCnt), 192'(0));
    rst_s = 1'b0; sbus.FlushE = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("sat_flush%0d", k), 192'(sbus.BubbleCnt), 192'((k > 3) ? 3 : k));
      chk($sformatf("sat_valid%0d", k), 192'(sbus.ValidE), 192'(0));
    end
    sbus.FlushE = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      chk($sformatf("sat_hold%0d", k), 192'(sbus.BubbleCnt), 192'(3));
    end
    sbus.FlushE = 1'b1; rst_s = 1'b1;
    @(posedge clk); #1;
    chk("sat_rst_flush", 192'(sbus.BubbleCnt), 192'(0));
    sbus.FlushE = 1'b0; rst_s = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
